mem_port_arbiter: RTL

//  Shares one fixed-latency main-memory port between I-cache (line fill) and D-cache (fill/write-back).

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory port between I-cache fills and D-cache fills/write-backs.
// A four-state FSM serialises accesses and returns each completion as a registered one-cycle done pulse.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int LINE_W  = 64,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_busy,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC_I, ACC_D, RESP} state_e;

  localparam logic       SIDE_I   = 1'b0;
  localparam logic       SIDE_D   = 1'b1;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                owner_q, owner_d;
  logic                last_gnt_q, last_gnt_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_done_q, i_done_d;
  logic                d_done_q, d_done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= SIDE_I;
      last_gnt_q  <= SIDE_I;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_gnt_q  <= last_gnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_gnt_d  = last_gnt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie the side that was not served last wins, which alternates I and D.
        if (d_req && (!i_req || last_gnt_q == SIDE_I)) begin
          state_d     = ACC_D;
          cnt_d       = CNT_LOAD;
          owner_d     = SIDE_D;
          last_gnt_d  = SIDE_D;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (i_req) begin
          state_d    = ACC_I;
          cnt_d      = CNT_LOAD;
          owner_d    = SIDE_I;
          last_gnt_d = SIDE_I;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = i_addr;
        end
      end
      ACC_I, ACC_D: begin
        if (cnt_q == 8'd0) begin
          state_d  = RESP;
          mem_en_d = 1'b0;
          if (state_q == ACC_I) begin
            i_rdata_d = mem_rdata;
            i_done_d  = 1'b1;
          end else begin
            if (!mem_we_q) d_rdata_d = mem_rdata;
            d_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign i_busy    = i_req & ~(state_q == RESP && owner_q == SIDE_I);
  assign d_busy    = d_req & ~(state_q == RESP && owner_q == SIDE_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
